// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes a 4-digit hex value onto a common-anode 4-digit seven-segment display.
//   Each digit gets a dark guard slot (BLANK_CYC cycles) followed by a drive slot
//   (REFRESH_DIV cycles). Display settings go through a staging register, then a shadow
//   register. The shadow is reloaded only at the frame boundary, so a frame never mixes
//   old and new data.
//
// Ports
//   clk100    in   board clock, rising edge
//   rst       in   asynchronous active-high reset
//   value     in   [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   dig_en    in   per-digit enable, 1=digit may light
//   dp_mask   in   per-digit decimal point, 1=lit
//   lz_blank  in   1=blank leading zeros on digits 3..1
//   upd       in   capture value/dig_en/dp_mask/lz_blank into staging
//   an        out  anode selects, active low, registered
//   led_out   out  segments {dp,g,f,e,d,c,b,a}, active low, registered
//   frame     out  one-cycle pulse after each frame boundary
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dig_en,
    input  logic [3:0]  dp_mask,
    input  logic        lz_blank,
    input  logic        upd,
    output logic [3:0]  an,
    output logic [7:0]  led_out,
    output logic        frame
);

    localparam int unsigned MaxCyc = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
    localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);

    typedef enum logic {StBlank, StDrive} state_e;

    typedef struct packed {
        logic        lz;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [15:0] value;
    } disp_cfg_t;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    disp_cfg_t         stg_q, stg_d, sh_q, sh_d, in_cfg;
    logic [3:0]        an_q, an_d;
    logic [7:0]        led_q, led_d;
    logic              frame_q, frame_d;

    logic              blank_done, drive_done, wrap;
    logic [3:0]        nib;
    logic              lz_hit;
    logic [6:0]        seg_pat;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign in_cfg     = {lz_blank, dp_mask, dig_en, value};
    assign blank_done = (state_q == StBlank) && (cnt_q == BlankLast);
    assign drive_done = (state_q == StDrive) && (cnt_q == DriveLast);
    assign wrap       = drive_done && (idx_q == 2'd3);

    // Staging takes every upd. At the wrap edge the shadow loads stg_d rather than stg_q,
    // so an upd landing on that same edge goes straight to the display.
    always_comb begin
        stg_d = upd ? in_cfg : stg_q;
        sh_d  = wrap ? stg_d : sh_q;
    end

    // Pattern for the digit about to be driven. Leading-zero blanking applies when this
    // nibble and every higher nibble are zero. Digit 0 is never blanked.
    always_comb begin
        nib     = sh_q.value[{idx_q, 2'b00} +: 4];
        lz_hit  = sh_q.lz && (idx_q != 2'd0) && ((sh_q.value >> {idx_q, 2'b00}) == 16'h0);
        seg_pat = lz_hit ? 7'h7F : hex_to_seg(nib);
    end

    // State register
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            stg_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            sh_q    <= sh_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        if (blank_done) begin
            state_d = StDrive;
            cnt_d   = '0;
        end else if (drive_done) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // Outputs change only on slot edges, so they stay constant for a whole slot.
    always_comb begin
        an_d    = an_q;
        led_d   = led_q;
        frame_d = wrap;
        if (blank_done) begin
            if (sh_q.en[idx_q]) begin
                an_d  = ~(4'b0001 << idx_q);
                led_d = {~sh_q.dp[idx_q], seg_pat};
            end else begin
                an_d  = 4'hF;
                led_d = 8'hFF;
            end
        end else if (drive_done) begin
            an_d  = 4'hF;
            led_d = 8'hFF;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            an_q    <= 4'hF;
            led_q   <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            led_q   <= led_d;
            frame_q <= frame_d;
        end
    end

    assign an      = an_q;
    assign led_out = led_q;
    assign frame   = frame_q;

endmodule
